// File: rtl/bus_arbiter_mo.sv
// Bus arbiter: N caches share one memory port; single-beat reads with an
// in-order response tracker, multi-beat write bursts locked to one cache.
module bus_arbiter_mo #(
    parameter int num_caches_p      = 2,
    parameter int block_width_p     = 4,
    parameter int dma_data_width_p  = 2,
    parameter int max_outstanding_p = 4,
    parameter int arb_mode_p        = 0,
    localparam int D_LP  = dma_data_width_p * 32,
    localparam int CW_LP = $clog2(max_outstanding_p + 1)
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic [num_caches_p-1:0]      cb_valid_i,
    output logic [num_caches_p-1:0]      cb_yumi_o,
    input  logic [num_caches_p-1:0]      cb_we_i,
    input  logic [num_caches_p*32-1:0]   cb_addr_i,
    input  logic [num_caches_p*D_LP-1:0] cb_wdata_i,
    output logic                         mem_valid_o,
    input  logic                         mem_ready_i,
    output logic                         mem_we_o,
    output logic [31:0]                  mem_addr_o,
    output logic [D_LP-1:0]              mem_wdata_o,
    input  logic                         mem_valid_i,
    input  logic [D_LP-1:0]              mem_data_i,
    output logic [num_caches_p-1:0]      cb_valid_o,
    output logic [D_LP-1:0]              cb_data_o,
    output logic [CW_LP-1:0]             pending_reads_o,
    output logic                         err_o,
    output logic                         dbg_state_o
);
    localparam int BEATS_LP = block_width_p / dma_data_width_p;
    localparam int IDW_LP   = (num_caches_p > 1) ? $clog2(num_caches_p) : 1;
    localparam int BCW_LP   = (BEATS_LP > 1) ? $clog2(BEATS_LP) : 1;
    localparam int PW_LP    = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
    localparam logic [BCW_LP-1:0] LAST_BEAT_LP = BCW_LP'(BEATS_LP - 1);
    localparam logic [PW_LP-1:0]  LAST_SLOT_LP = PW_LP'(max_outstanding_p - 1);
    localparam logic [IDW_LP-1:0] LAST_ID_LP   = IDW_LP'(num_caches_p - 1);

    typedef enum logic {IDLE = 1'b0, WBURST = 1'b1} state_e;

    state_e                    r_state, w_state_nxt;
    logic [BCW_LP-1:0]         r_beat;
    logic [IDW_LP-1:0]         r_rr_ptr;
    logic [IDW_LP-1:0]         r_lock_id;
    logic [31:0]               r_burst_addr;
    logic [IDW_LP-1:0]         r_fifo [max_outstanding_p];
    logic [PW_LP-1:0]          r_wptr, r_rptr;
    logic [CW_LP-1:0]          r_count;
    logic [BCW_LP-1:0]         r_resp_cnt;
    logic [num_caches_p-1:0]   r_pend;
    logic                      r_err;

    logic                      w_full, w_resp_valid, w_pop, w_push, w_accept;
    logic                      w_grant_any;
    logic [IDW_LP-1:0]         w_head, w_grant_id, w_gnt;
    logic [num_caches_p-1:0]   w_pop_mask, w_push_mask, w_elig;
    int                        w_idx;

    assign w_full       = (r_count == CW_LP'(max_outstanding_p));
    assign w_head       = r_fifo[r_rptr];
    assign w_resp_valid = mem_valid_i & (r_count != '0) & ~reset_i;
    assign w_pop        = w_resp_valid & (r_resp_cnt == LAST_BEAT_LP);

    // A pop in this cycle frees both the head's pending bit and a tracker slot.
    always_comb begin
        w_pop_mask = '0;
        if (w_pop) w_pop_mask[w_head] = 1'b1;
        for (int i = 0; i < num_caches_p; i++) begin
            w_elig[i] = cb_valid_i[i] & ~(r_pend[i] & ~w_pop_mask[i])
                        & (cb_we_i[i] | ~w_full | w_pop);
        end
        w_grant_any = 1'b0;
        w_grant_id  = '0;
        w_idx       = 0;
        for (int i = 0; i < num_caches_p; i++) begin
            w_idx = (arb_mode_p == 0) ? ((int'(r_rr_ptr) + i) % num_caches_p) : i;
            if (!w_grant_any && w_elig[w_idx]) begin
                w_grant_any = 1'b1;
                w_grant_id  = IDW_LP'(w_idx);
            end
        end
    end

    assign w_gnt       = (r_state == WBURST) ? r_lock_id : w_grant_id;
    assign mem_valid_o = ~reset_i & ((r_state == WBURST) ? cb_valid_i[r_lock_id] : w_grant_any);
    assign w_accept    = mem_valid_o & mem_ready_i;
    assign mem_we_o    = (r_state == WBURST) ? 1'b1 : cb_we_i[w_gnt];
    assign mem_addr_o  = (r_state == WBURST) ? r_burst_addr : cb_addr_i[w_gnt*32 +: 32];
    assign mem_wdata_o = cb_wdata_i[w_gnt*D_LP +: D_LP];
    assign w_push      = w_accept & (r_state == IDLE) & ~cb_we_i[w_gnt];

    always_comb begin
        cb_yumi_o   = '0;
        w_push_mask = '0;
        cb_valid_o  = '0;
        w_state_nxt = r_state;
        if (w_accept) cb_yumi_o[w_gnt] = 1'b1;
        if (w_push) w_push_mask[w_gnt] = 1'b1;
        if (w_resp_valid) cb_valid_o[w_head] = 1'b1;
        case (r_state)
            IDLE:    if (w_accept && cb_we_i[w_gnt] && BEATS_LP > 1) w_state_nxt = WBURST;
            WBURST:  if (w_accept && r_beat == LAST_BEAT_LP) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign cb_data_o       = mem_data_i;
    assign pending_reads_o = reset_i ? '0 : r_count;
    assign err_o           = r_err & ~reset_i;
    assign dbg_state_o     = r_state;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state      <= IDLE;
            r_beat       <= '0;
            r_rr_ptr     <= '0;
            r_lock_id    <= '0;
            r_burst_addr <= '0;
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_resp_cnt   <= '0;
            r_pend       <= '0;
            r_err        <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                if (r_state == IDLE) begin
                    if (arb_mode_p == 0) r_rr_ptr <= (w_gnt == LAST_ID_LP) ? '0 : w_gnt + 1'b1;
                    if (cb_we_i[w_gnt] && BEATS_LP > 1) begin
                        r_beat       <= BCW_LP'(1);
                        r_lock_id    <= w_gnt;
                        r_burst_addr <= cb_addr_i[w_gnt*32 +: 32];
                    end
                end else begin
                    r_beat <= (r_beat == LAST_BEAT_LP) ? '0 : r_beat + 1'b1;
                end
            end
            if (w_push) r_wptr <= (r_wptr == LAST_SLOT_LP) ? '0 : r_wptr + 1'b1;
            if (w_pop)  r_rptr <= (r_rptr == LAST_SLOT_LP) ? '0 : r_rptr + 1'b1;
            r_count <= r_count + CW_LP'(w_push) - CW_LP'(w_pop);
            if (w_resp_valid) r_resp_cnt <= w_pop ? '0 : r_resp_cnt + 1'b1;
            // Push wins over pop so a cache can reissue in the cycle its read retires.
            r_pend <= (r_pend & ~w_pop_mask) | w_push_mask;
            if (mem_valid_i && r_count == '0) r_err <= 1'b1;
        end
    end

    // When full, the pushed id lands in the head slot being popped this cycle.
    always_ff @(posedge clk_i) begin
        if (w_push) r_fifo[r_wptr] <= w_gnt;
    end
endmodule

// File: tb/tb_bus_arbiter_mo.sv
// Directed bench for bus_arbiter_mo: N=2, two beats per block, two reads in flight.
module tb_bus_arbiter_mo;
    localparam int N  = 2;
    localparam int D  = 64;
    localparam int CW = 2;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic [N-1:0]  cb_valid_i, cb_yumi_o, cb_we_i, cb_valid_o;
    logic [N*32-1:0] cb_addr_i;
    logic [N*D-1:0]  cb_wdata_i;
    logic          mem_valid_o, mem_ready_i, mem_we_o, mem_valid_i, err_o, dbg_state_o;
    logic [31:0]   mem_addr_o;
    logic [D-1:0]  mem_wdata_o, mem_data_i, cb_data_o;
    logic [CW-1:0] pending_reads_o;

    int n_cmp = 0;
    int n_mis = 0;
    logic [N-1:0] exp_q[$];

    bus_arbiter_mo #(
        .num_caches_p(2), .block_width_p(4), .dma_data_width_p(2),
        .max_outstanding_p(2), .arb_mode_p(0)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .cb_valid_i(cb_valid_i), .cb_yumi_o(cb_yumi_o), .cb_we_i(cb_we_i),
        .cb_addr_i(cb_addr_i), .cb_wdata_i(cb_wdata_i),
        .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_valid_i(mem_valid_i), .mem_data_i(mem_data_i),
        .cb_valid_o(cb_valid_o), .cb_data_o(cb_data_o),
        .pending_reads_o(pending_reads_o), .err_o(err_o), .dbg_state_o(dbg_state_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int c, input logic v, input logic we,
                         input logic [31:0] addr, input logic [63:0] wd);
        cb_valid_i[c]          = v;
        cb_we_i[c]             = we;
        cb_addr_i[c*32 +: 32]  = addr;
        cb_wdata_i[c*D +: D]   = wd;
    endtask

    // Drain response beats; the routing expectation comes from exp_q.
    task automatic resp_beats(input int n, input int pend_first);
        for (int b = 0; b < n; b++) begin
            @(negedge clk_i);
            mem_valid_i = 1'b1;
            mem_data_i  = 64'hD000 + 64'(b);
            #1;
            check_eq("resp_route", cb_valid_o, exp_q.pop_front());
            check_eq("resp_data", cb_data_o, 64'hD000 + 64'(b));
            check_eq("resp_pend", pending_reads_o, 64'(pend_first - b / 2));
        end
        @(negedge clk_i);
        mem_valid_i = 1'b0;
        #1;
        check_eq("drain_pend", pending_reads_o, 0);
    endtask

    initial begin
        reset_i = 1'b1; cb_valid_i = '0; cb_we_i = '0; cb_addr_i = '0; cb_wdata_i = '0;
        mem_ready_i = 1'b0; mem_valid_i = 1'b0; mem_data_i = '0;
        repeat (2) @(negedge clk_i);
        drive(0, 1, 0, 32'h100, 0); drive(1, 1, 0, 32'h200, 0);
        mem_ready_i = 1'b1; mem_valid_i = 1'b1;
        #1;
        check_eq("rst_yumi", cb_yumi_o, 0);
        check_eq("rst_mvalid", mem_valid_o, 0);
        check_eq("rst_cbvalid", cb_valid_o, 0);
        check_eq("rst_pend", pending_reads_o, 0);
        check_eq("rst_err", err_o, 0);
        check_eq("rst_state", dbg_state_o, 0);

        // Simultaneous reads, round-robin from pointer 0.
        @(negedge clk_i);
        reset_i = 1'b0; mem_valid_i = 1'b0;
        #1;
        check_eq("rr_yumi0", cb_yumi_o, 2'b01);
        check_eq("rr_addr0", mem_addr_o, 32'h100);
        check_eq("rr_we0", mem_we_o, 0);
        check_eq("rr_pend0", pending_reads_o, 0);
        @(negedge clk_i); #1;
        check_eq("rr_yumi1", cb_yumi_o, 2'b10);
        check_eq("rr_addr1", mem_addr_o, 32'h200);
        check_eq("rr_pend1", pending_reads_o, 1);
        @(negedge clk_i); #1;
        check_eq("rr_blocked", mem_valid_o, 0);
        check_eq("rr_pend2", pending_reads_o, 2);
        cb_valid_i = '0;

        // In-order responses: head 0 for two beats, then head 1.
        exp_q = '{2'b01, 2'b01, 2'b10, 2'b10};
        resp_beats(4, 2);

        // Full tracker: pop on head's last beat admits a new read the same cycle.
        @(negedge clk_i);
        drive(0, 1, 0, 32'h110, 0);
        #1; check_eq("fill_yumi0", cb_yumi_o, 2'b01);
        @(negedge clk_i);
        drive(0, 0, 0, 0, 0); drive(1, 1, 0, 32'h210, 0);
        #1; check_eq("fill_yumi1", cb_yumi_o, 2'b10);
        @(negedge clk_i);
        cb_valid_i = '0; mem_valid_i = 1'b1; mem_data_i = 64'h11;
        #1;
        check_eq("full_beat1", cb_valid_o, 2'b01);
        check_eq("full_pend", pending_reads_o, 2);
        @(negedge clk_i);
        drive(0, 1, 0, 32'h120, 0); mem_data_i = 64'h12;
        #1;
        check_eq("pop_push_yumi", cb_yumi_o, 2'b01);
        check_eq("pop_push_route", cb_valid_o, 2'b01);
        check_eq("pop_push_pend", pending_reads_o, 2);
        @(negedge clk_i);
        cb_valid_i = '0; mem_valid_i = 1'b0;
        #1; check_eq("after_pp_pend", pending_reads_o, 2);
        exp_q = '{2'b10, 2'b10, 2'b01, 2'b01};
        resp_beats(4, 2);

        // Write burst from cache 1 with beat 2 stalled while cache 0 waits.
        @(negedge clk_i);
        drive(0, 1, 0, 32'h130, 0); drive(1, 1, 1, 32'h300, 64'hAAAA);
        #1;
        check_eq("wr_yumi_b1", cb_yumi_o, 2'b10);
        check_eq("wr_we", mem_we_o, 1);
        check_eq("wr_addr_b1", mem_addr_o, 32'h300);
        check_eq("wr_data_b1", mem_wdata_o, 64'hAAAA);
        check_eq("wr_state_b1", dbg_state_o, 0);
        @(negedge clk_i);
        drive(1, 1, 1, 32'h308, 64'hBBBB); mem_ready_i = 1'b0;
        for (int s = 0; s < 3; s++) begin
            if (s > 0) @(negedge clk_i);
            #1;
            check_eq("stall_yumi", cb_yumi_o, 0);
            check_eq("stall_mvalid", mem_valid_o, 1);
            check_eq("stall_addr", mem_addr_o, 32'h300);
            check_eq("stall_data", mem_wdata_o, 64'hBBBB);
            check_eq("stall_state", dbg_state_o, 1);
        end
        @(negedge clk_i);
        mem_ready_i = 1'b1;
        #1;
        check_eq("wr_yumi_b2", cb_yumi_o, 2'b10);
        check_eq("wr_addr_b2", mem_addr_o, 32'h300);
        @(negedge clk_i);
        drive(1, 0, 0, 0, 0);
        #1;
        check_eq("post_wr_state", dbg_state_o, 0);
        check_eq("post_wr_yumi", cb_yumi_o, 2'b01);
        check_eq("post_wr_addr", mem_addr_o, 32'h130);
        @(negedge clk_i);
        cb_valid_i = '0;
        #1; check_eq("post_wr_pend", pending_reads_o, 1);
        exp_q = '{2'b01, 2'b01};
        resp_beats(2, 1);

        // Unexpected response with an empty tracker.
        @(negedge clk_i);
        mem_valid_i = 1'b1;
        #1;
        check_eq("orphan_route", cb_valid_o, 0);
        check_eq("orphan_err_now", err_o, 0);
        @(negedge clk_i);
        mem_valid_i = 1'b0;
        #1; check_eq("err_set", err_o, 1);
        @(negedge clk_i); #1;
        check_eq("err_sticky", err_o, 1);
        @(negedge clk_i);
        reset_i = 1'b1;
        #1; check_eq("err_in_rst", err_o, 0);
        @(negedge clk_i);
        reset_i = 1'b0;
        #1; check_eq("err_cleared", err_o, 0);

        // Reset during a burst with a read in flight abandons both.
        @(negedge clk_i);
        drive(1, 1, 0, 32'h240, 0);
        #1; check_eq("pre_rst_rd", cb_yumi_o, 2'b10);
        @(negedge clk_i);
        drive(1, 0, 0, 0, 0); drive(0, 1, 1, 32'h400, 64'hCCCC);
        #1;
        check_eq("pre_rst_wr", cb_yumi_o, 2'b01);
        check_eq("pre_rst_pend", pending_reads_o, 1);
        @(negedge clk_i);
        reset_i = 1'b1; drive(0, 1, 1, 32'h408, 64'hDDDD);
        #1;
        check_eq("midrst_state", dbg_state_o, 1);
        check_eq("midrst_mvalid", mem_valid_o, 0);
        check_eq("midrst_yumi", cb_yumi_o, 0);
        check_eq("midrst_pend", pending_reads_o, 0);
        @(negedge clk_i);
        reset_i = 1'b0; cb_valid_i = '0; cb_we_i = '0;
        #1;
        check_eq("postrst_state", dbg_state_o, 0);
        check_eq("postrst_pend", pending_reads_o, 0);
        @(negedge clk_i);
        mem_valid_i = 1'b1;
        #1; check_eq("stale_route", cb_valid_o, 0);
        @(negedge clk_i);
        mem_valid_i = 1'b0;
        drive(0, 1, 0, 32'h500, 0); drive(1, 1, 0, 32'h600, 0);
        #1;
        check_eq("stale_err", err_o, 1);
        check_eq("postrst_rr", cb_yumi_o, 2'b01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/bus_arbiter_mo.md
BUS_ARBITER_MO -- requirements
Module: bus_arbiter_mo

Interface
- REQ-001 SHALL have parameter num_caches_p, default 2: number of requesting caches, 1..16.
- REQ-002 SHALL have parameter block_width_p, default 4: words per block.
- REQ-003 SHALL have parameter dma_data_width_p, default 2: words per bus beat; beats_lp = block_width_p/dma_data_width_p, which is an integer >= 1.
- REQ-004 SHALL have parameter max_outstanding_p, default 4: maximum reads in flight, >= 1.
- REQ-005 SHALL have parameter arb_mode_p, default 0: 0 = round-robin, 1 = fixed priority (lowest id wins).
- REQ-006 SHALL have the following ports (N = num_caches_p, D = dma_data_width_p*32, CW = $clog2(max_outstanding_p+1)), clock and reset first:
  - clk_i  in  1  sole clock.
  - reset_i  in  1  synchronous, active-high reset.
  - cb_valid_i  in  N  per-cache request/beat valid.
  - cb_yumi_o  out  N  per-cache beat accepted.
  - cb_we_i  in  N  per-cache write flag.
  - cb_addr_i  in  N x 32  per-cache address.
  - cb_wdata_i  in  N x D  per-cache write beat.
  - mem_valid_o  out  1  beat to memory valid.
  - mem_ready_i  in  1  memory accepts beat.
  - mem_we_o  out  1  write flag.
  - mem_addr_o  out  32  address.
  - mem_wdata_o  out  D  write data.
  - mem_valid_i  in  1  read response beat valid.
  - mem_data_i  in  D  read response data.
  - cb_valid_o  out  N  response beat routed to cache.
  - cb_data_o  out  D  response data (equals mem_data_i).
  - pending_reads_o  out  CW  reads in flight.
  - err_o  out  1  sticky unexpected-response flag.

Function
- REQ-007 A read request SHALL be one beat (address only); memory SHALL return beats_lp beats in request order.
- REQ-008 A write request SHALL be beats_lp consecutive beats from the same cache; mem_addr_o SHALL hold the first-beat address for every beat of the burst.
- REQ-009 The FSM SHALL have states IDLE and WBURST.
- REQ-010 In IDLE, the grant SHALL be chosen combinationally in the same cycle among eligible caches.
- REQ-011 A cache SHALL be eligible when cb_valid_i is set and it has no read in flight.
- REQ-012 A read SHALL additionally be eligible only if the tracker is not full, or a tracker pop occurs in the same cycle.
- REQ-013 mem_valid_o SHALL equal cb_valid_i of the granted cache; mem_valid_o SHALL NOT depend on mem_ready_i.
- REQ-014 cb_yumi_o[g] SHALL equal mem_valid_o & mem_ready_i for the granted cache g; all other bits SHALL be 0.
- REQ-015 An accepted first write beat with beats_lp > 1 SHALL move IDLE -> WBURST and lock the grant to that cache.
- REQ-016 The beat counter SHALL increment on each accepted beat; the last accepted beat (count = beats_lp-1) SHALL return the FSM to IDLE.
- REQ-017 When beats_lp = 1, WBURST SHALL never be entered.
- REQ-018 During WBURST, no other cache SHALL receive yumi; a stalled beat (mem_ready_i = 0) SHALL hold all mem outputs stable.
- REQ-019 Round-robin: after an accepted first beat from cache k, the highest-priority cache SHALL become (k+1) mod N; the pointer SHALL be 0 after reset.
- REQ-020 Fixed priority: the pointer SHALL be ignored.
- REQ-021 The read tracker SHALL be a FIFO of depth max_outstanding_p holding cache ids, pushed on an accepted read.
- REQ-022 A response beat SHALL set cb_valid_o only at the head id; the FIFO SHALL pop on the beats_lp-th response beat; push and pop SHALL be allowed in the same cycle, including when full.
- REQ-023 The per-cache read-pending bit SHALL be set on push and cleared on pop.
- REQ-024 On the same cycle, a pop-clear of a cache's pending bit SHALL make that cache eligible in that cycle.
- REQ-025 pending_reads_o SHALL equal the tracker occupancy (0..max_outstanding_p).
- REQ-026 mem_valid_i with an empty tracker SHALL be ignored (no cb_valid_o) and SHALL set err_o until reset.
- REQ-027 With num_caches_p = 1, arbitration SHALL degenerate to always granting cache 0.

Reset
- REQ-028 While reset_i is high, cb_yumi_o, mem_valid_o, cb_valid_o, pending_reads_o, and err_o SHALL be 0.
- REQ-029 On reset, the FSM SHALL go to IDLE, and the beat counter, RR pointer, tracker, and pending bits SHALL clear.
- REQ-030 Reset mid-burst or with reads in flight SHALL abandon them; responses arriving after reset SHALL set err_o.

Verification (N=2, beats_lp=2, max_outstanding_p=2)
- REQ-031 Caches 0 and 1 both request a read at the same cycle in round-robin mode -> cache 0 gets yumi first, cache 1 next cycle; pending_reads_o goes 1 then 2.
- REQ-032 Cache 1 issues a write (2 beats) with mem_ready_i low on beat 2 for 3 cycles while cache 0 is valid -> mem_addr_o stable; cache 0 gets no yumi until cycle after beat 2 accepted.
- REQ-033 Two reads outstanding (0 then 1), 4 response beats -> cb_valid_o = 01,01,10,10; pending_reads_o 2,2,1,0 afterwards.
- REQ-034 Tracker full and 2nd response beat of head coincides with a new read request -> request accepted same cycle; pending_reads_o stays 2.
- REQ-035 mem_valid_i with tracker empty -> cb_valid_o = 0, err_o = 1 until reset_i.
- REQ-036 reset_i asserted during WBURST beat 1 -> next cycle FSM IDLE, mem_valid_o 0 while reset high, RR pointer 0.
